// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_e;

    // Bit positions inside io_lcd_o; [7:0] carries DATA.
    localparam int LCD_ON = 11;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    // Power-up command sequence, entry 0 is sent first.
    localparam logic [3:0][7:0] INIT_ROM  = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Commands that need the long execution wait (clear, home, home variant).
    localparam logic [2:0][7:0] LONG_CMDS = {8'h03, 8'h02, 8'h01};

    function automatic logic is_long(input logic rs, input logic [7:0] d);
        logic hit;
        hit = 1'b0;
        if (!rs) begin
            for (int i = 0; i < 3; i++) begin
                if (d == LONG_CMDS[i]) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // A zero-cycle phase makes no sense on the wire; run it for one cycle.
    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase of the controller.
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Load wins; otherwise count down and park at zero (never wraps).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             cnt_q <= '0;
        else if (load_i)         cnt_q <= value_i;
        else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
    end

    // A phase of N cycles is loaded with N-1, so zero marks its last cycle.
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: power-up wait, fixed init sequence, then
// request-driven command/data writes with SETUP/PULSE/HOLD/WAIT timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 1,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int PWRUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    output logic        req_ready_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic [11:0] io_lcd_o
);

    localparam int SETUP_C = clamp1(SETUP_CYC);
    localparam int PULSE_C = clamp1(PULSE_CYC);
    localparam int HOLD_C  = clamp1(HOLD_CYC);
    localparam int EXEC_C  = clamp1(EXEC_CYC);
    localparam int LONG_C  = clamp1(LONG_CYC);
    localparam int PWRUP_C = clamp1(PWRUP_CYC);

    localparam int M0    = (SETUP_C > PULSE_C) ? SETUP_C : PULSE_C;
    localparam int M1    = (HOLD_C  > EXEC_C)  ? HOLD_C  : EXEC_C;
    localparam int M2    = (LONG_C  > PWRUP_C) ? LONG_C  : PWRUP_C;
    localparam int M3    = (M0 > M1) ? M0 : M1;
    localparam int MAX_C = (M3 > M2) ? M3 : M2;
    localparam int CW    = $clog2(MAX_C + 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic        init_done_q;
    logic        armed_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        en_q;
    logic        on_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;
    logic          pwr_end;
    logic          ready;

    assign ready = (state_q == S_IDLE) && init_done_q;

    lcd_timer #(.W(CW)) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    // Timer reload on every phase change. The counter is zero out of reset,
    // so the first power-up cycle arms it with the remaining PWRUP_C-1 cycles.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        pwr_end  = armed_q ? tmr_done : (PWRUP_C == 1);
        case (state_q)
            S_PWRUP: begin
                if (pwr_end) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_C - 1);
                end else if (!armed_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(PWRUP_C - 2);
                end
            end
            S_IDLE: begin
                if (ready && req_valid_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_C - 1);
                end
            end
            S_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(PULSE_C - 1);
                end
            end
            S_PULSE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_C - 1);
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = is_long(rs_q, data_q) ? CW'(LONG_C - 1) : CW'(EXEC_C - 1);
                end
            end
            S_WAIT: begin
                if (tmr_done && !init_done_q && idx_q != 2'd3) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_C - 1);
                end
            end
            default: ;
        endcase
    end

    // Main FSM with registered pin drivers; reset drops EN asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_PWRUP;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            armed_q     <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            on_q <= 1'b1;
            case (state_q)
                S_PWRUP: begin
                    armed_q <= 1'b1;
                    if (pwr_end) begin
                        state_q <= S_SETUP;
                        rs_q    <= 1'b0;
                        data_q  <= INIT_ROM[0];
                    end
                end
                S_IDLE: begin
                    if (ready && req_valid_i) begin
                        state_q <= S_SETUP;
                        rs_q    <= req_rs_i;
                        data_q  <= req_data_i;
                    end
                end
                S_SETUP: begin
                    if (tmr_done) begin
                        state_q <= S_PULSE;
                        en_q    <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (tmr_done) begin
                        state_q <= S_HOLD;
                        en_q    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (tmr_done) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tmr_done) begin
                        if (init_done_q) begin
                            state_q <= S_IDLE;
                        end else if (idx_q == 2'd3) begin
                            init_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_SETUP;
                            rs_q    <= 1'b0;
                            data_q  <= INIT_ROM[idx_q + 2'd1];
                        end
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

    assign req_ready_o = ready;
    assign busy_o      = (state_q != S_IDLE);
    assign init_done_o = init_done_q;
    assign io_lcd_o    = {on_q, en_q, rs_q, 1'b0, data_q};

endmodule
